// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: MIDI byte parser and voice-slot allocator driving one-cycle synth event strobes.
// Define ALL_NOTES_OFF_EN to turn CC 0xBn 0x7B into a per-channel release sweep.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 128,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rx_overflow,
    output logic              note_pressed,
    output logic              note_released,
    output logic              note_keypress,
    output logic              pitch_wheel,
    output logic [6:0]        note,
    output logic [6:0]        velocity,
    output logic [3:0]        channel,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] active_count
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_VOICES - 1);
    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
    typedef enum logic [1:0] {OP_ON, OP_OFF, OP_KP, OP_ANO} op_t;

    state_t state, state_n;
    op_t op, op_n;
    logic [7:0] status;
    logic st_valid, dcnt;
    logic [6:0] d0, m_note, m_vel, e_note;
    logic [3:0] m_ch, e_ch, hi;
    logic [ADDR_W-1:0] idx, slot, ma, fa, steal_ptr;
    logic fm, ff, is_free, is_steal;
    logic [NUM_VOICES-1:0] tbl_act;
    logic [3:0] tbl_ch [NUM_VOICES];
    logic [6:0] tbl_note [NUM_VOICES];
    logic acc, done, bend, scan_msg, ano, e_act, hit, last, use_match, use_free;

    assign rx_ready    = state == IDLE;
    assign rx_overflow = rx_valid & ~rx_ready;
    assign acc         = rx_valid & rx_ready;
    assign hi          = status[7:4];
    assign done        = acc & ~rx_data[7] & st_valid & dcnt;
`ifdef ALL_NOTES_OFF_EN
    assign ano = hi == 4'hB && d0 == 7'h7B;
`else
    assign ano = 1'b0;
`endif
    assign bend     = done & (hi == 4'hE);
    assign scan_msg = done & (hi == 4'h8 | hi == 4'h9 | hi == 4'hA | ano);
    assign op_n     = hi == 4'hA ? OP_KP : hi == 4'hB ? OP_ANO :
                      (hi == 4'h8 || rx_data[6:0] == 7'd0) ? OP_OFF : OP_ON;

    // Entry under the scan pointer; the all-notes-off sweep matches on channel only
    assign e_act     = tbl_act[idx[IW-1:0]];
    assign e_ch      = tbl_ch[idx[IW-1:0]];
    assign e_note    = tbl_note[idx[IW-1:0]];
    assign hit       = e_act && e_ch == m_ch && (op == OP_ANO || e_note == m_note);
    assign last      = idx == LAST;
    assign use_match = fm | hit;
    assign use_free  = ff | ~e_act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = scan_msg ? SCAN : IDLE;
            SCAN:    state_n = (op == OP_ON ? last : hit) ? EMIT : last ? IDLE : SCAN;
            EMIT:    state_n = (op == OP_ANO && !last) ? SCAN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {note_pressed, note_released, note_keypress, pitch_wheel} <= '0;
            {note, velocity, channel, addr, active_count} <= '0;
            {status, st_valid, dcnt, d0, m_note, m_vel, m_ch} <= '0;
            {idx, slot, ma, fa, steal_ptr, fm, ff, is_free, is_steal} <= '0;
            op      <= OP_ON;
            tbl_act <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tbl_ch[i]   <= '0;
                tbl_note[i] <= '0;
            end
        end else begin
            {note_pressed, note_released, note_keypress, pitch_wheel} <= '0;
            if (acc && rx_data[7]) begin
                if (rx_data < 8'hF0) begin
                    status   <= rx_data;
                    st_valid <= 1'b1;
                    dcnt     <= 1'b0;
                end else if (rx_data < 8'hF8) st_valid <= 1'b0;
            end else if (acc && st_valid && hi != 4'hC && hi != 4'hD) begin
                if (!dcnt) d0 <= rx_data[6:0];
                dcnt <= ~dcnt;
            end
            if (bend) begin
                pitch_wheel <= 1'b1;
                note        <= rx_data[6:0];
                velocity    <= d0;
                channel     <= status[3:0];
                addr        <= '0;
            end
            if (scan_msg) begin
                op     <= op_n;
                m_ch   <= status[3:0];
                m_note <= d0;
                m_vel  <= hi == 4'hB ? 7'd0 : rx_data[6:0];
                fm     <= 1'b0;
                ff     <= 1'b0;
            end
            if (state_n == SCAN) idx <= state == IDLE ? '0 : idx + 1'b1;
            // Note-on keeps a running slot choice so the last scan cycle already holds the answer
            if (state == SCAN && op == OP_ON) begin
                if (hit && !fm) begin
                    fm <= 1'b1;
                    ma <= idx;
                end
                if (!e_act && !ff) begin
                    ff <= 1'b1;
                    fa <= idx;
                end
                slot     <= use_match ? (fm ? ma : idx) : use_free ? (ff ? fa : idx) : steal_ptr;
                is_free  <= !use_match && use_free;
                is_steal <= !use_match && !use_free;
            end else if (state == SCAN && hit) begin
                slot   <= idx;
                m_note <= e_note;
            end
            if (state == EMIT) begin
                note          <= m_note;
                velocity      <= m_vel;
                channel       <= m_ch;
                addr          <= slot;
                note_pressed  <= op == OP_ON;
                note_released <= op == OP_OFF || op == OP_ANO;
                note_keypress <= op == OP_KP;
                if (op == OP_ON) begin
                    tbl_act[slot[IW-1:0]]  <= 1'b1;
                    tbl_ch[slot[IW-1:0]]   <= m_ch;
                    tbl_note[slot[IW-1:0]] <= m_note;
                end else if (op != OP_KP) tbl_act[slot[IW-1:0]] <= 1'b0;
                if (op == OP_ON && is_free && active_count != FULL) active_count <= active_count + 1'b1;
                else if (op != OP_ON && op != OP_KP && active_count != '0) active_count <= active_count - 1'b1;
                if (op == OP_ON && is_steal) steal_ptr <= steal_ptr == LAST ? '0 : steal_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: directed and randomized checks of midi_voice_alloc against a voice-table model.
module tb_midi_voice_alloc;
    localparam int NV = 128;

    logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = '0;
    logic rx_ready, rx_overflow, note_pressed, note_released, note_keypress, pitch_wheel;
    logic [6:0] note, velocity;
    logic [3:0] channel;
    logic [7:0] addr, active_count;

    midi_voice_alloc #(.NUM_VOICES(NV), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_overflow(rx_overflow),
        .note_pressed(note_pressed), .note_released(note_released),
        .note_keypress(note_keypress), .pitch_wheel(pitch_wheel),
        .note(note), .velocity(velocity), .channel(channel),
        .addr(addr), .active_count(active_count)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [6:0]  nt;
        logic [6:0]  vel;
        logic [3:0]  ch;
        logic [7:0]  addr;
        logic [31:0] cyc;
    } ev_t;

    int n_checks = 0, n_fail = 0, cyc = 0, last_cyc = 0;
    ev_t got[$];
    bit m_act[NV];
    int m_ch[NV], m_nt[NV];
    int m_count, m_steal;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        ev_t e;
        int s;
        s = int'(note_pressed) + int'(note_released) + int'(note_keypress) + int'(pitch_wheel);
        if (s != 0) begin
            n_checks++;
            if (s != 1) begin
                n_fail++;
                $display("FAIL strobe_onehot: %0d strobes high, required 1", s);
            end
            e.kind = note_pressed ? 3'd1 : note_released ? 3'd2 : note_keypress ? 3'd3 : 3'd4;
            e.nt = note; e.vel = velocity; e.ch = channel; e.addr = addr; e.cyc = cyc;
            got.push_back(e);
        end
    end

    // Voice-table model: returns expected event with cyc = latency after the final byte
    function automatic ev_t model(input int st, input int d1, input int d2);
        ev_t e;
        int hi, ch, j;
        e = '0; hi = st >> 4; ch = st & 15; j = -1;
        if (hi == 14) e = '{3'd4, 7'(d2), 7'(d1), 4'(ch), 8'd0, 32'd1};
        else if (hi == 9 && d2 != 0) begin
            for (int i = 0; i < NV; i++) if (m_act[i] && m_ch[i] == ch && m_nt[i] == d1) begin j = i; break; end
            if (j < 0) for (int i = 0; i < NV; i++) if (!m_act[i]) begin j = i; m_count++; break; end
            if (j < 0) begin j = m_steal; m_steal = (m_steal + 1) % NV; end
            m_act[j] = 1; m_ch[j] = ch; m_nt[j] = d1;
            e = '{3'd1, 7'(d1), 7'(d2), 4'(ch), 8'(j), 32'(NV + 2)};
        end else if (hi == 8 || hi == 9 || hi == 10) begin
            for (int i = 0; i < NV; i++) if (m_act[i] && m_ch[i] == ch && m_nt[i] == d1) begin j = i; break; end
            if (j >= 0) begin
                e = '{(hi == 10) ? 3'd3 : 3'd2, 7'(d1), 7'(d2), 4'(ch), 8'(j), 32'(j + 3)};
                if (hi != 10) begin m_act[j] = 0; m_count--; end
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < NV; i++) m_act[i] = 0;
        m_count = 0; m_steal = 0;
        @(negedge clk);
        got.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_valid = 1'b1; last_cyc = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        int k;
        k = 0;
        while (!rx_ready && k < 400) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        if (k >= 400) begin
            n_checks++; n_fail++;
            $display("FAIL settle_timeout: rx_ready still %b after %0d cycles, required 1", rx_ready, k);
        end
    endtask

    task automatic play(input int st, input bit send_st, input bit rt, input int d1, input int d2, output ev_t e);
        got.delete();
        if (send_st) send(8'(st));
        send(8'(d1));
        if (rt) send(8'hF8);
        send(8'(d2));
        e = model(st, d1, d2);
        if (e.kind != 0) e.cyc = e.cyc + 32'(last_cyc);
        settle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({note_pressed, note_released, note_keypress, pitch_wheel, rx_overflow} !== 5'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b required 00000",
                {note_pressed, note_released, note_keypress, pitch_wheel, rx_overflow});
        end
        n_checks++;
        if ({note, velocity, channel, addr, active_count} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0", {note, velocity, channel, addr, active_count});
        end
        n_checks++;
        if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", rx_ready); end
    endtask

    task automatic test_note_on();
        ev_t e, x;
        do_reset();
        play(8'h90, 1, 0, 8'h3C, 8'h64, e);
        x = '{3'd1, 7'h3C, 7'h64, 4'd0, 8'd0, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL note_on: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        n_checks++;
        if (active_count !== 8'd1) begin n_fail++; $display("FAIL note_on_count: got %0d required 1", active_count); end
    endtask

    task automatic test_running_status();
        ev_t e, x;
        do_reset();
        play(8'h91, 1, 0, 8'h40, 8'h50, e);
        play(8'h91, 0, 0, 8'h41, 8'h50, e);
        x = '{3'd1, 7'h41, 7'h50, 4'd1, 8'd1, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL running_on: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        play(8'h91, 0, 0, 8'h40, 8'h00, e);
        x = '{3'd2, 7'h40, 7'h00, 4'd1, 8'd0, 32'(last_cyc + 3)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL running_off: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        n_checks++;
        if (active_count !== 8'd1) begin n_fail++; $display("FAIL running_count: got %0d required 1", active_count); end
    endtask

    task automatic test_off_nomatch_realtime();
        ev_t e, x;
        do_reset();
        play(8'h80, 1, 0, 8'h3C, 8'h00, e);
        n_checks++;
        if (got.size() != 0 || active_count !== 8'd0) begin
            n_fail++; $display("FAIL off_nomatch: got %0d events count %0d required 0 and 0", got.size(), active_count);
        end
        play(8'h95, 1, 1, 8'h3C, 8'h64, e);
        x = '{3'd1, 7'h3C, 7'h64, 4'd5, 8'd0, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL realtime_insert: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
    endtask

    task automatic test_steal();
        ev_t e, x;
        do_reset();
        for (int i = 0; i < NV; i++) play(8'h91, i == 0, 0, i, 8'h40, e);
        n_checks++;
        if (active_count !== 8'(NV)) begin n_fail++; $display("FAIL fill_count: got %0d required %0d", active_count, NV); end
        play(8'h90, 1, 0, 8'h7F, 8'h10, e);
        x = '{3'd1, 7'h7F, 7'h10, 4'd0, 8'd0, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL steal_first: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        play(8'h90, 0, 0, 8'h7E, 8'h10, e);
        x = '{3'd1, 7'h7E, 7'h10, 4'd0, 8'd1, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL steal_second: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        n_checks++;
        if (active_count !== 8'(NV)) begin n_fail++; $display("FAIL steal_count: got %0d required %0d", active_count, NV); end
    endtask

    task automatic test_pitch_keypress();
        ev_t e, x;
        do_reset();
        play(8'hE2, 1, 0, 8'h00, 8'h50, e);
        x = '{3'd4, 7'h50, 7'h00, 4'd2, 8'd0, 32'(last_cyc + 1)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL pitch_wheel: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        play(8'h92, 1, 0, 8'h30, 8'h40, e);
        play(8'h92, 0, 0, 8'h31, 8'h40, e);
        play(8'hA2, 1, 0, 8'h31, 8'h22, e);
        x = '{3'd3, 7'h31, 7'h22, 4'd2, 8'd1, 32'(last_cyc + 4)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL keypress: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
    endtask

    task automatic test_overflow();
        ev_t e, x;
        int t;
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        t = last_cyc;
        @(posedge clk); #1 rx_data = 8'h45; rx_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rx_overflow !== 1'b1 || rx_ready !== 1'b0) begin
            n_fail++; $display("FAIL overflow_pulse: got ovf %b ready %b required 1 0", rx_overflow, rx_ready);
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        e = model(8'h90, 8'h3C, 8'h64);
        settle();
        x = '{3'd1, 7'h3C, 7'h64, 4'd0, 8'd0, 32'(t + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL overflow_note: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
        play(8'h90, 0, 0, 8'h3D, 8'h50, e);
        x = '{3'd1, 7'h3D, 7'h50, 4'd0, 8'd1, 32'(last_cyc + NV + 2)};
        n_checks++;
        if (got.size() != 1 || got[0] !== x) begin
            n_fail++; $display("FAIL overflow_dropped: got %0d events first %h required %h", got.size(), got.size() ? got[0] : '0, x);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (got.size() != 0 || active_count !== 8'd0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_scan: got %0d events count %0d ready %b required 0 0 1",
                got.size(), active_count, rx_ready);
        end
    endtask

    task automatic test_random();
        ev_t e;
        int his[6];
        int st, last_st, d1, d2;
        bit send_st;
        his = '{8, 9, 9, 9, 10, 14};
        do_reset();
        last_st = -1;
        for (int n = 0; n < 50; n++) begin
            st = (his[$urandom % 6] << 4) | int'($urandom % 4);
            d1 = 8'h30 + int'($urandom % 6);
            d2 = ($urandom % 4 == 0) ? 0 : int'($urandom % 128);
            send_st = (st != last_st) || ($urandom % 2 == 1);
            play(st, send_st, $urandom % 5 == 0, d1, d2, e);
            last_st = st;
            n_checks++;
            if (got.size() != ((e.kind != 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL random_count[%0d]: got %0d events required %0d", n, got.size(), (e.kind != 0) ? 1 : 0);
            end else if (e.kind != 0) begin
                n_checks++;
                if (got[0] !== e) begin n_fail++; $display("FAIL random_event[%0d]: got %h required %h", n, got[0], e); end
            end
            n_checks++;
            if (active_count !== 8'(m_count)) begin
                n_fail++; $display("FAIL random_active[%0d]: got %0d required %0d", n, active_count, m_count);
            end
        end
    endtask

`ifdef ALL_NOTES_OFF_EN
    task automatic test_all_notes_off();
        ev_t e;
        logic [6:0] nts[3];
        logic [7:0] ads[3];
        nts = '{7'h30, 7'h32, 7'h33};
        ads = '{8'd0, 8'd2, 8'd3};
        do_reset();
        play(8'h90, 1, 0, 8'h30, 8'h40, e);
        play(8'h91, 1, 0, 8'h31, 8'h40, e);
        play(8'h90, 1, 0, 8'h32, 8'h40, e);
        play(8'h90, 0, 0, 8'h33, 8'h40, e);
        got.delete();
        send(8'hB0); send(8'h7B); send(8'h00);
        settle();
        n_checks++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL ano_count: got %0d strobes required 3", got.size());
        end else for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i].kind !== 3'd2 || got[i].nt !== nts[i] || got[i].ch !== 4'd0 || got[i].addr !== ads[i]) begin
                n_fail++; $display("FAIL ano_event[%0d]: got %h required release note %h addr %0d", i, got[i], nts[i], ads[i]);
            end
        end
        n_checks++;
        if (active_count !== 8'd1) begin n_fail++; $display("FAIL ano_active: got %0d required 1", active_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_off_nomatch_realtime();
        test_pitch_keypress();
        test_overflow();
        test_reset_mid_scan();
        test_random();
        test_steal();
`ifdef ALL_NOTES_OFF_EN
        test_all_notes_off();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
